step_scheduler: RTL



---
 rtl/step_sched_pkg.sv | 20 ++
 rtl/step_rr_arbiter.sv | 35 +++
 rtl/step_scheduler.sv | 136 +++++++++++++
 3 files changed

// File: rtl/step_sched_pkg.sv
// Shared FSM encoding, parameter defaults and width helper for the step scheduler.
package step_sched_pkg;

  localparam int DEF_NUM_CORES       = 2;
  localparam int DEF_STEP_WIDTH      = 8;
  localparam int DEF_ACC_WIDTH       = 16;
  localparam int DEF_BATCH_THRESHOLD = 64;
  localparam int DEF_TIMEOUT         = 255;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HALT  = 2'd2
  } sched_state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/step_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after i_ptr, wrapping.
// Zero latency; no flow control of its own.
module step_rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_vld
);

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_vld = 1'b0;
    // Upper segment [ptr, N) first, then wrap to [0, ptr).
    for (int j = 0; j < N; j++) begin
      if (!o_vld && i_req[j] && (IW'(j) >= i_ptr)) begin
        o_vld    = 1'b1;
        o_gnt[j] = 1'b1;
        o_idx    = IW'(j);
      end
    end
    for (int j = 0; j < N; j++) begin
      if (!o_vld && i_req[j]) begin
        o_vld    = 1'b1;
        o_gnt[j] = 1'b1;
        o_idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/step_scheduler.sv
// Accumulates per-core steps and issues one batch at a time; out_valid follows eligibility by 1 cycle.
// A batch is held stable until out_ready; steps arriving meanwhile stay in the accumulator.
module step_scheduler
  import step_sched_pkg::*;
#(
  parameter int NUM_CORES       = DEF_NUM_CORES,
  parameter int STEP_WIDTH      = DEF_STEP_WIDTH,
  parameter int ACC_WIDTH       = DEF_ACC_WIDTH,
  parameter int BATCH_THRESHOLD = DEF_BATCH_THRESHOLD,
  parameter int TIMEOUT         = DEF_TIMEOUT,
  localparam int IW             = idx_width(NUM_CORES)
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [NUM_CORES*STEP_WIDTH-1:0]  in_step,
  input  logic [7:0]                       sim_result,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [IW-1:0]                    out_core,
  output logic [ACC_WIDTH-1:0]             out_step,
  output logic                             halted,
  output logic                             overflow
);

  localparam logic [ACC_WIDTH-1:0] THR = ACC_WIDTH'(BATCH_THRESHOLD);
  localparam logic [7:0]           TMO = 8'(TIMEOUT);

  sched_state_t r_state, w_state_nxt;

  logic [ACC_WIDTH-1:0] r_acc [NUM_CORES];
  logic [7:0]           r_idle [NUM_CORES];
  logic [ACC_WIDTH-1:0] w_base [NUM_CORES];
  logic [ACC_WIDTH:0]   w_sum [NUM_CORES];
  logic [ACC_WIDTH-1:0] w_acc_nxt [NUM_CORES];
  logic [NUM_CORES-1:0] w_clip;
  logic [NUM_CORES-1:0] w_elig;
  logic [NUM_CORES-1:0] w_gnt_oh;
  logic [IW-1:0]        w_gnt_idx;
  logic                 w_gnt_any;
  logic [IW-1:0]        r_rr_next;
  logic [IW-1:0]        r_out_core;
  logic [ACC_WIDTH-1:0] r_out_step;
  logic                 r_stop_pend;
  logic                 r_overflow;
  logic                 w_stop;
  logic                 w_grant;
  logic                 w_hs;

  assign w_stop    = |sim_result;
  assign out_valid = (r_state == ST_ISSUE);
  assign halted    = (r_state == ST_HALT);
  assign out_core  = r_out_core;
  assign out_step  = r_out_step;
  assign overflow  = r_overflow;
  assign w_hs      = out_valid && out_ready;
  assign w_grant   = (r_state == ST_IDLE) && !w_stop && w_gnt_any;

  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      w_elig[i] = (r_acc[i] >= THR) || ((r_acc[i] != '0) && (r_idle[i] >= TMO));
    end
  end

  step_rr_arbiter #(.N(NUM_CORES), .IW(IW)) u_arb (
    .i_req (w_elig),
    .i_ptr (r_rr_next),
    .o_gnt (w_gnt_oh),
    .o_idx (w_gnt_idx),
    .o_vld (w_gnt_any)
  );

  // The issued core gives back its snapshot in the same cycle it keeps accumulating.
  always_comb begin
    for (int i = 0; i < NUM_CORES; i++) begin
      w_base[i]    = (w_hs && (r_out_core == IW'(i))) ? (r_acc[i] - r_out_step) : r_acc[i];
      w_sum[i]     = {1'b0, w_base[i]} + (ACC_WIDTH+1)'(in_step[i*STEP_WIDTH +: STEP_WIDTH]);
      w_clip[i]    = w_sum[i][ACC_WIDTH];
      w_acc_nxt[i] = w_clip[i] ? '1 : w_sum[i][ACC_WIDTH-1:0];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_stop)         w_state_nxt = ST_HALT;
        else if (w_gnt_any) w_state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (out_ready) w_state_nxt = (w_stop || r_stop_pend) ? ST_HALT : ST_IDLE;
      end
      ST_HALT:  w_state_nxt = ST_HALT;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_CORES; i++) begin
        r_acc[i]  <= '0;
        r_idle[i] <= '0;
      end
      r_rr_next   <= '0;
      r_out_core  <= '0;
      r_out_step  <= '0;
      r_stop_pend <= 1'b0;
      r_overflow  <= 1'b0;
    end else if (r_state != ST_HALT) begin
      for (int i = 0; i < NUM_CORES; i++) begin
        r_acc[i] <= w_acc_nxt[i];
        // A core being granted or in flight is being served, so it is not idle.
        if ((r_acc[i] == '0) || (w_grant && w_gnt_oh[i]) || (out_valid && (r_out_core == IW'(i))))
          r_idle[i] <= '0;
        else if (r_idle[i] != 8'hFF)
          r_idle[i] <= r_idle[i] + 8'd1;
      end
      if (|w_clip) r_overflow <= 1'b1;
      if (w_grant) begin
        r_out_core <= w_gnt_idx;
        r_out_step <= r_acc[w_gnt_idx];
        r_rr_next  <= (w_gnt_idx == IW'(NUM_CORES - 1)) ? '0 : w_gnt_idx + 1'b1;
      end
      if (out_valid && w_stop) r_stop_pend <= 1'b1;
    end
  end

endmodule
